or_cell_tester: RTL
===================

OR_CELL_TESTER -- requirements
Module: or_cell_tester

Interface
- REQ-001: The block SHALL have parameter SETTLE_CYCLES, default 3: cycles each input vector is held before the output is sampled. Legal range 1..255.
- REQ-002: Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: Port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-004: Port start, input, 1 bit: request a test run; sampled only in IDLE.
- REQ-005: Port abort, input, 1 bit: synchronous cancel of an in-progress run.
- REQ-006: Port dut_a, output, 1 bit: drives input A of the external OR cell.
- REQ-007: Port dut_b, output, 1 bit: drives input B of the external OR cell.
- REQ-008: Port dut_c, input, 1 bit: output C of the external OR cell.
- REQ-009: Port busy, output, 1 bit: high in every state except IDLE.
- REQ-010: Port done, output, 1 bit: one-cycle pulse when a run completes.
- REQ-011: Port pass, output, 1 bit: high when the last completed run had zero mismatches.
- REQ-012: Port err_vec, output, 4 bits: bit k set when vector k mismatched.
- REQ-013: Port err_count, output, 3 bits: number of mismatching vectors, 0..4.

Function
- REQ-014: The block SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
- REQ-015: Vector k (k = 0..3) SHALL drive dut_a = k[1] and dut_b = k[0]; the expected result is dut_a OR dut_b.
- REQ-016: In IDLE with start = 1 in cycle T, the block SHALL:
  - clear err_vec, err_count and pass;
  - set the vector index to 0 and drive vector 0 from cycle T+1;
  - load the settle counter and enter SETTLE.
- REQ-017: SETTLE SHALL last exactly SETTLE_CYCLES cycles with the vector held stable, then go to SAMPLE.
- REQ-018: In SAMPLE, the block SHALL compare dut_c with the expected result. On mismatch it SHALL set err_vec[k] and increment err_count.
- REQ-019: From SAMPLE with k < 3, the block SHALL increment k, drive the new vector from the next cycle, reload the settle counter and re-enter SETTLE. The old vector SHALL stay driven during the SAMPLE cycle itself.
- REQ-020: From SAMPLE with k = 3, the block SHALL enter DONE.
- REQ-021: Cycle timing SHALL be:
  - vector k is driven from cycle T+1+k*(SETTLE_CYCLES+1);
  - vector k is sampled in cycle T+(k+1)*(SETTLE_CYCLES+1);
  - DONE occupies cycle T+4*(SETTLE_CYCLES+1)+1.
- REQ-022: In DONE, the block SHALL assert done for exactly one cycle and set pass = (err_vec == 0). It SHALL return to IDLE the next cycle with dut_a = dut_b = 0.
- REQ-023: pass, err_vec and err_count SHALL hold their values after DONE until the next accepted start or reset.
- REQ-024: start SHALL be ignored while busy = 1. start asserted in the DONE cycle SHALL also be ignored.
- REQ-025: abort = 1 in SETTLE or SAMPLE SHALL move the block to IDLE on the next edge with dut_a = dut_b = 0. done SHALL NOT pulse and pass SHALL remain 0. abort SHALL take priority over the SAMPLE comparison in the same cycle.
- REQ-026: abort in IDLE or DONE SHALL have no effect.
- REQ-027: All outputs SHALL be registered, with no combinational path from inputs to outputs.
- REQ-028: err_count SHALL saturate at 4 and SHALL never wrap.

Reset
- REQ-029: rst_n = 0 SHALL immediately force:
  - state IDLE;
  - dut_a = dut_b = busy = done = pass = 0;
  - err_vec = 0000 and err_count = 0.
- REQ-030: Reset asserted mid-run SHALL discard all partial results; no done pulse SHALL follow.
- REQ-031: After rst_n deasserts, the first rising edge SHALL be able to accept start.

Verification
- REQ-032: Good OR model, SETTLE_CYCLES = 3, start at T -> done at T+17, pass = 1, err_vec = 0000, err_count = 0; dut_a/dut_b sequence 00, 01, 10, 11, each held 4 cycles.
- REQ-033: dut_c stuck at 0 -> pass = 0, err_vec = 1110, err_count = 3.
- REQ-034: NOR model (inverted output) -> pass = 0, err_vec = 1111, err_count = 4.
- REQ-035: start pulsed at T+5 during a run -> ignored; exactly one done, at T+17.
- REQ-036: abort at T+6 -> IDLE at T+7, busy = 0, dut_a = dut_b = 0, no done pulse. A following start runs a clean full test.
- REQ-037: rst_n low at T+9 -> all outputs 0 immediately; after release, a new start completes normally with pass = 1.

Source files
------------

// File: rtl/or_cell_tester.sv
// ---------------------------------------------------------------------------
// or_cell_tester
//
// Exhaustively exercises an external two-input OR cell. Drives the four
// input vectors (a,b) = 00, 01, 10, 11 in order. Holds each vector for
// SETTLE_CYCLES cycles, then samples the cell output on the next cycle.
// Records which vectors mismatched and reports a pass/fail summary.
//
// Parameters
//   SETTLE_CYCLES : cycles a vector is held before it is sampled (1..255)
//
// Ports
//   clk       in   clock, rising-edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request a run (only honoured in IDLE)
//   abort     in   cancel a run in progress (SETTLE/SAMPLE)
//   dut_a     out  OR cell input A
//   dut_b     out  OR cell input B
//   dut_c     in   OR cell output C
//   busy      out  high whenever not IDLE
//   done      out  one-cycle pulse at the end of a completed run
//   pass      out  last completed run had no mismatches
//   err_vec   out  bit k set when vector k mismatched
//   err_count out  number of mismatching vectors (0..4)
// ---------------------------------------------------------------------------
module or_cell_tester #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec,
    output logic [2:0] err_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // The counter counts down to zero, so loading N-1 gives N SETTLE cycles.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] settle_cnt;
    logic [1:0] vec_idx;
    logic       mismatch;

    // The vector under test is still driven during SAMPLE, so the expected
    // value comes straight from the registered cell inputs.
    assign mismatch = (dut_c != (dut_a | dut_b));

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd4 : v + 3'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_idx    <= '0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_vec    <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err_vec    <= '0;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        vec_idx    <= 2'd0;
                        dut_a      <= 1'b0;
                        dut_b      <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end

                SAMPLE: begin
                    // Abort wins: the pending comparison is simply dropped.
                    if (abort) begin
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (mismatch) begin
                            err_vec[vec_idx] <= 1'b1;
                            err_count        <= sat_inc(err_count);
                        end
                        if (vec_idx != 2'd3) begin
                            vec_idx        <= vec_idx + 2'd1;
                            {dut_a, dut_b} <= vec_idx + 2'd1;
                            settle_cnt     <= SETTLE_LOAD;
                            state          <= SETTLE;
                        end else begin
                            // Fold in the final comparison so pass is valid
                            // in the same cycle as the done pulse.
                            pass  <= (err_vec == 4'b0000) && !mismatch;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    dut_a <= 1'b0;
                    dut_b <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
